// File: rtl/pred_sched_pkg.sv
// pred_pkg: shared types and helpers for the DRSSTC phase-lead predictor
// scheduler (pred_sched) and its half-period measurement block (hp_meas).
//   state_t  - encoded scheduler state, also exported on the debug port
//   cnt_w    - counter width able to hold values 0..n
//   sat_inc  - increment that sticks at a ceiling instead of wrapping
package pred_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_LOCK  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/pred_sched_hp_meas.sv
// hp_meas: feedback edge detector and half-period meter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart the half-period counter (start of a burst)
//   fb        - feedback polarity, already synchronised to clk
//   fb_edge   - fb differs from its registered copy this cycle
//   edge_ok   - fb_edge whose measured half-period is below CNT_MAX
//   hp_cur    - most recent half-period in clocks (saturating)
//   hp_prev   - half-period before hp_cur
//   lost      - counter lands on / sits at CNT_MAX with no edge this cycle
module hp_meas
    import pred_pkg::*;
#(
    parameter  int CNT_MAX = 255,
    localparam int W       = cnt_w(CNT_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         fb,
    output logic         fb_edge,
    output logic         edge_ok,
    output logic [W-1:0] hp_cur,
    output logic [W-1:0] hp_prev,
    output logic         lost
);

    localparam logic [W-1:0] MAX_V = W'(CNT_MAX);

    logic         fb_d;
    logic [W-1:0] hp_cnt;
    logic [W-1:0] hp_cnt_inc;

    assign fb_edge    = fb ^ fb_d;
    assign hp_cnt_inc = W'(sat_inc(32'(hp_cnt), CNT_MAX));

    // The value captured on an edge is hp_cnt+1, so hp_cnt == CNT_MAX-1 is
    // the first count whose capture would hit CNT_MAX. Flagging lost there
    // makes it coincide with the clock on which hp_cnt itself reaches
    // CNT_MAX, and it stays asserted while the counter is saturated.
    assign edge_ok = fb_edge && (hp_cnt < MAX_V - W'(1));
    assign lost    = !fb_edge && (hp_cnt >= MAX_V - W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_d    <= 1'b0;
            hp_cnt  <= '0;
            hp_cur  <= '0;
            hp_prev <= '0;
        end else begin
            fb_d <= fb;
            if (clr) begin
                hp_cnt <= '0;
            end else if (fb_edge) begin
                hp_cur  <= hp_cnt_inc;
                hp_prev <= hp_cur;
                hp_cnt  <= '0;
            end else begin
                hp_cnt <= hp_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/pred_sched.sv
// pred_sched: burst sequencer for the DRSSTC feedback phase-lead predictor.
// Runs an open-loop start-up oscillation, waits for feedback to lock, then
// hands gate drive to the predictor with shift = mean half-period - lead.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - burst enable from the interrupter
//   fb         - synchronised primary-current feedback polarity
//   lead       - requested phase lead in clocks
//   shift      - predictor shift value (never 0)
//   shift_vld  - shift is in use (RUN only)
//   drv        - open-loop start-up drive level
//   drv_sel    - 1: gate drive from drv, 0: from predictor
//   fault      - feedback lost, held until the next burst starts
//   state      - encoded state for debug
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no burst; waiting for en rising
//   START | open-loop drive for START_CYCLES periods, noting any feedback
//   LOCK  | open-loop drive continues; counting consecutive good edges
//   RUN   | closed loop; predictor drives the gates, shift tracks edges
//   FAULT | feedback absent or lost; drive off until en falls
module pred_sched
    import pred_pkg::*;
#(
    parameter  int CNT_MAX      = 255,
    parameter  int START_HALF   = 100,
    parameter  int START_CYCLES = 3,
    parameter  int LOCK_EDGES   = 4,
    localparam int W            = cnt_w(CNT_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         fb,
    input  logic [W-1:0] lead,
    output logic [W-1:0] shift,
    output logic         shift_vld,
    output logic         drv,
    output logic         drv_sel,
    output logic         fault,
    output logic [2:0]   state
);

    localparam int HW    = cnt_w(START_HALF);
    localparam int TOGS  = 2 * START_CYCLES;
    localparam int TW    = cnt_w(TOGS);
    localparam int LW    = cnt_w(LOCK_EDGES);

    state_t        state_q;
    logic          en_d;
    logic [HW-1:0] half_cnt;
    logic [TW-1:0] tog_cnt;
    logic [LW-1:0] lock_cnt;
    logic          seen;
    logic          edge_q;

    logic          fb_edge;
    logic          edge_ok;
    logic          lost;
    logic          clr;
    logic [W-1:0]  hp_cur;
    logic [W-1:0]  hp_prev;
    logic [W:0]    hp_sum;
    logic [W-1:0]  hp_avg;
    logic [W-1:0]  shift_calc;
    logic          boundary;

    assign state = 3'(state_q);
    assign clr   = (state_q == ST_IDLE) && en && !en_d;

    hp_meas #(.CNT_MAX(CNT_MAX)) u_hp_meas (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .fb      (fb),
        .fb_edge (fb_edge),
        .edge_ok (edge_ok),
        .hp_cur  (hp_cur),
        .hp_prev (hp_prev),
        .lost    (lost)
    );

    // Widened sum so two near-CNT_MAX half-periods cannot wrap.
    assign hp_sum     = {1'b0, hp_prev} + {1'b0, hp_cur};
    assign hp_avg     = W'(hp_sum >> 1);
    assign shift_calc = (hp_avg > lead) ? hp_avg - lead : W'(1);
    assign boundary   = (half_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            // Held high so an en already high when reset lifts is not
            // mistaken for a new burst.
            en_d      <= 1'b1;
            half_cnt  <= '0;
            tog_cnt   <= '0;
            lock_cnt  <= '0;
            seen      <= 1'b0;
            edge_q    <= 1'b0;
            shift     <= W'(1);
            shift_vld <= 1'b0;
            drv       <= 1'b0;
            drv_sel   <= 1'b1;
            fault     <= 1'b0;
        end else begin
            en_d   <= en;
            edge_q <= fb_edge;

            if (edge_q && (state_q == ST_LOCK || state_q == ST_RUN)) begin
                shift <= shift_calc;
            end

            if (state_q != ST_IDLE && !en) begin
                state_q   <= ST_IDLE;
                drv       <= 1'b0;
                drv_sel   <= 1'b1;
                shift_vld <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        drv       <= 1'b0;
                        drv_sel   <= 1'b1;
                        shift_vld <= 1'b0;
                        if (clr) begin
                            state_q  <= ST_START;
                            fault    <= 1'b0;
                            drv      <= 1'b1;
                            half_cnt <= HW'(START_HALF - 1);
                            tog_cnt  <= TW'(1);
                            lock_cnt <= '0;
                            seen     <= 1'b0;
                        end
                    end

                    ST_START: begin
                        seen <= seen | fb_edge;
                        if (boundary) begin
                            half_cnt <= HW'(START_HALF - 1);
                            if (tog_cnt == TW'(TOGS)) begin
                                if (seen || fb_edge) begin
                                    state_q <= ST_LOCK;
                                    drv     <= ~drv;
                                end else begin
                                    state_q <= ST_FAULT;
                                    fault   <= 1'b1;
                                    drv     <= 1'b0;
                                end
                            end else begin
                                drv     <= ~drv;
                                tog_cnt <= tog_cnt + TW'(1);
                            end
                        end else begin
                            half_cnt <= half_cnt - HW'(1);
                        end
                    end

                    ST_LOCK: begin
                        if (lost) begin
                            state_q  <= ST_FAULT;
                            lock_cnt <= '0;
                            fault    <= 1'b1;
                            drv      <= 1'b0;
                        end else if (boundary && lock_cnt == LW'(LOCK_EDGES)) begin
                            // Switching only on a toggle boundary avoids a
                            // truncated open-loop pulse at handover.
                            state_q   <= ST_RUN;
                            drv_sel   <= 1'b0;
                            shift_vld <= 1'b1;
                            drv       <= 1'b0;
                        end else begin
                            if (boundary) begin
                                drv      <= ~drv;
                                half_cnt <= HW'(START_HALF - 1);
                            end else begin
                                half_cnt <= half_cnt - HW'(1);
                            end
                            if (fb_edge) begin
                                if (!edge_ok) begin
                                    lock_cnt <= '0;
                                end else if (lock_cnt != LW'(LOCK_EDGES)) begin
                                    lock_cnt <= lock_cnt + LW'(1);
                                end
                            end
                        end
                    end

                    ST_RUN: begin
                        if (lost) begin
                            state_q   <= ST_FAULT;
                            shift_vld <= 1'b0;
                            drv_sel   <= 1'b1;
                            drv       <= 1'b0;
                            fault     <= 1'b1;
                        end
                    end

                    ST_FAULT: begin
                        fault <= 1'b1;
                        drv   <= 1'b0;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pred_sched.sv
// Self-checking bench for pred_sched (CNT_MAX=255, START_HALF=100,
// START_CYCLES=3, LOCK_EDGES=4). Cycle numbers count rising clock edges;
// an input changed after edge n is sampled at edge n+1.
module tb_pred_sched;

    logic       clk = 1'b0;
    logic       rst, en, fb;
    logic [7:0] lead, shift;
    logic       shift_vld, drv, drv_sel, fault;
    logic [2:0] state;

    always #5 clk = ~clk;

    pred_sched #(
        .CNT_MAX(255), .START_HALF(100), .START_CYCLES(3), .LOCK_EDGES(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .fb(fb), .lead(lead),
        .shift(shift), .shift_vld(shift_vld), .drv(drv), .drv_sel(drv_sel),
        .fault(fault), .state(state)
    );

    typedef struct {
        int h_a;
        int h_b;
        int ld;
        int exp_shift;
    } vec_t;

    vec_t vecs[7];
    int   exp_q[$];

    int checks = 0, failures = 0, cyc = 0;
    int run_cyc, lock_cyc, fault_cyc, t0, last_edge, drv_changes, drv_bad;
    int run_shift, run_vld, run_sel, pre_sel;
    logic       mon_drv = 1'b0;
    logic [2:0] prev_state = 3'd0;
    logic       prev_drv = 1'b0, prev_sel = 1'b1;

    localparam int RESET_VEC = int'({8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (state != prev_state) begin
            if (state == 3'd2) lock_cyc = cyc;
            if (state == 3'd3) begin
                run_cyc   = cyc;
                run_shift = int'(shift);
                run_vld   = int'(shift_vld);
                run_sel   = int'(drv_sel);
                pre_sel   = int'(prev_sel);
            end
            if (state == 3'd4) fault_cyc = cyc;
        end
        if (mon_drv && drv != prev_drv) begin
            drv_changes++;
            if ((cyc - t0) % 100 != 0) drv_bad++;
        end
        prev_state = state;
        prev_drv   = drv;
        prev_sel   = drv_sel;
    endtask

    task automatic half(input int h);
        fb        = ~fb;
        last_edge = cyc + 1;
        repeat (h) step();
    endtask

    function automatic int out_vec();
        return int'({shift, shift_vld, drv, drv_sel, fault, state});
    endfunction

    // Feedback half-period 80 from the first START cycle, lead 10.
    // START ends 600 clocks in; LOCK edges at +640/+720/+800/+880, so the
    // 4th good edge precedes the +900 toggle boundary where RUN begins.
    task automatic lock_up();
        lead        = 8'd10;
        run_cyc     = -1;
        lock_cyc    = -1;
        drv_changes = 0;
        drv_bad     = 0;
        en          = 1'b1;
        t0          = cyc + 1;
        mon_drv     = 1'b1;
        for (int k = 0; k < 40 && run_cyc < 0; k++) half(80);
        mon_drv = 1'b0;
        check("lock_entry_cycle", lock_cyc - t0, 600);
        check("run_entry_cycle", run_cyc - t0, 900);
        check("run_entry_shift", run_shift, 70);
        check("run_entry_shift_vld", run_vld, 1);
        check("run_entry_drv_sel", run_sel, 0);
        check("pre_run_drv_sel", pre_sel, 1);
        check("startup_drv_changes", drv_changes, 10);
        check("startup_drv_off_grid", drv_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nonidle;
        int exp_v;

        vecs[0] = '{h_a: 80,  h_b: 80,  ld: 10,  exp_shift: 70};
        vecs[1] = '{h_a: 20,  h_b: 20,  ld: 30,  exp_shift: 1};
        vecs[2] = '{h_a: 60,  h_b: 80,  ld: 0,   exp_shift: 70};
        vecs[3] = '{h_a: 100, h_b: 100, ld: 100, exp_shift: 1};
        vecs[4] = '{h_a: 200, h_b: 200, ld: 5,   exp_shift: 195};
        vecs[5] = '{h_a: 100, h_b: 60,  ld: 20,  exp_shift: 60};
        vecs[6] = '{h_a: 50,  h_b: 50,  ld: 48,  exp_shift: 2};

        rst  = 1'b1;
        en   = 1'b0;
        fb   = 1'b0;
        lead = 8'd0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("power_on_outputs", out_vec(), RESET_VEC);
        end
        rst = 1'b0;
        step();
        check("idle_after_reset", out_vec(), RESET_VEC);

        lock_up();

        // Closed-loop shift tracking through a table of feedback patterns.
        foreach (vecs[i]) begin
            lead = 8'(vecs[i].ld);
            repeat (3) begin
                half(vecs[i].h_a);
                half(vecs[i].h_b);
            end
            exp_q.push_back(vecs[i].exp_shift);
            step();
            exp_v = exp_q.pop_front();
            check($sformatf("run_shift_vec%0d", i), int'(shift), exp_v);
            check($sformatf("run_shift_vld_vec%0d", i), int'(shift_vld), 1);
        end

        // Feedback stops in RUN.
        fault_cyc = -1;
        for (int i = 0; i < 400 && fault_cyc < 0; i++) step();
        check("loss_delay", fault_cyc - last_edge, 255);
        check("loss_shift_vld", int'(shift_vld), 0);
        check("loss_drv_sel", int'(drv_sel), 1);
        check("loss_fault", int'(fault), 1);
        check("loss_drv", int'(drv), 0);

        en = 1'b0;
        step();
        check("fault_en_low_state", int'(state), 0);
        check("fault_sticky_in_idle", int'(fault), 1);
        check("idle_drv_sel", int'(drv_sel), 1);

        // No feedback at all.
        en = 1'b1;
        t0 = cyc + 1;
        step();
        check("nofb_start_state", int'(state), 1);
        check("nofb_fault_cleared", int'(fault), 0);
        fault_cyc = -1;
        for (int i = 0; i < 700 && fault_cyc < 0; i++) step();
        check("nofb_fault_delay", fault_cyc - t0, 600);
        check("nofb_fault", int'(fault), 1);
        check("nofb_drv", int'(drv), 0);
        en = 1'b0;
        step();
        check("nofb_idle", int'(state), 0);

        // en dropped during START while drv is high.
        en = 1'b1;
        step();
        repeat (50) step();
        check("start_drv_high", int'(drv), 1);
        en = 1'b0;
        step();
        check("start_abort_state", int'(state), 0);
        check("start_abort_drv", int'(drv), 0);
        check("start_abort_drv_sel", int'(drv_sel), 1);

        // Reset in the middle of RUN with en held high.
        step();
        lock_up();
        rst = 1'b1;
        step();
        check("mid_run_reset_outputs", out_vec(), RESET_VEC);
        rst = 1'b0;
        nonidle = 0;
        for (int i = 0; i < 240; i++) begin
            if (i % 80 == 0) fb = ~fb;
            step();
            if (state != 3'd0) nonidle++;
        end
        check("no_restart_while_en_high", nonidle, 0);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check("restart_after_en_cycle", int'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
